dac_update_sequencer: RTL
=========================

# dac_update_sequencer

Serial-configured update controller for the DAC core. It receives addressed serial frames on one pin and holds VREF and DATA codes in shadow registers. It transfers both codes to the DAC-facing outputs on a load request, then holds `busy` for a programmable settle period and pulses `done` when the period ends. It sits between the chip's dedicated inputs and the DAC code/reference lines, replacing per-field free-running shift chains with one framed, checked interface.

## Interface
Parameters:
- `DATA_W`, 8: DAC data code width and frame payload width.
- `VREF_W`, 4: reference code width, taken from the payload LSBs.
- `SETTLE_RST`, 16: reset value of the settle-period register.

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sin`, input, 1: serial frame data, MSB-first.
- `sval`, input, 1: bit strobe. `sin` is sampled only on edges where `sval`=1.
- `ldac`, input, 1: load request, level-sampled each edge.
- `vref_out`, output, `VREF_W`: active reference code.
- `data_out`, output, `DATA_W`: active DAC data code.
- `busy`, output, 1: update in progress (settling).
- `done`, output, 1: one-cycle pulse when settling ends.
- `err`, output, 1: sticky flag for a parity error on the last frame.

## Operation
- Frame format, counted in strobed bits: start bit `1`, then `addr[1:0]`, then `payload[DATA_W-1:0]`, then parity. Parity is even over addr and payload, so the XOR of all addr, payload and parity bits equals 0.
- The receive FSM has four states: `RX_IDLE`, `RX_ADDR`, `RX_PAY`, `RX_PAR`.
  - `RX_IDLE`: a strobed `1` moves to `RX_ADDR`. Strobed `0` bits are ignored.
  - `RX_ADDR` counts 2 bits, then `RX_PAY` counts `DATA_W` bits, then `RX_PAR` takes 1 bit and returns to `RX_IDLE`.
- Frame acceptance, on the parity-bit edge:
  - Parity good: the addressed register is written on that same edge, and `err` is cleared.
  - Parity bad: the frame is discarded and `err` is set to 1.
  - A start bit does not change `err`.
- Address map:
  - `00`: VREF shadow, written from `payload[VREF_W-1:0]`. Upper payload bits are ignored.
  - `01`: DATA shadow.
  - `10`: settle register, 8 bits. A value of 0 is treated as 1.
  - `11`: control register. Bit 0 is `auto`. All other bits are ignored.
- The update FSM has two states: `U_IDLE` and `U_SETTLE`.
  - In `U_IDLE`, an update starts when `ldac`=1, or in the cycle after an accepted DATA frame while `auto`=1.
  - Update start edge: `vref_out` and `data_out` load from the shadows, `busy` goes to 1, the state moves to `U_SETTLE`, and the counter loads the settle value.
  - `U_SETTLE` decrements the counter each cycle. At 1 it returns to `U_IDLE`, `busy` goes to 0 and `done` goes to 1 for one cycle.
- `ldac` seen while in `U_SETTLE` sets a 1-deep `pending` flag. Further requests while pending are dropped. A pending update starts on the edge after the `done` cycle, and `pending` clears.
- The receiver runs independently of the update FSM. Shadows may be rewritten during settling.

## Timing
- Reset values: `vref_out`=0, `data_out`=0, `busy`=0, `done`=0, `err`=0, shadows 0, settle register `SETTLE_RST`, `auto`=0, `pending`=0. Both FSMs start in idle.
- Frame latency: the shadow or register value is visible on the edge that samples the parity bit. A minimum frame is 12 strobed bits with `DATA_W`=8.
- `ldac` latency: high at edge k, so outputs and `busy` change at edge k.
- Busy period: `busy` stays high for exactly max(S,1) cycles, where S is the settle register value captured at start. `done` is high in the following cycle.
- Auto mode: DATA frame accepted at edge k, so the update starts at edge k+1.
- Simultaneous frame write and update start on the same edge: the outputs take the pre-edge shadow value, and the new value needs the next update.
- A write to the settle register during `U_SETTLE` affects only the next update.
- `rst_n` low at any time, including mid-frame or mid-settle, returns everything to the reset values immediately. No `done` is produced for the aborted update.

## Structure
- Package `dac_ctrl_pkg` holds:
  - address constants `ADDR_VREF`, `ADDR_DATA`, `ADDR_SETTLE`, `ADDR_CTRL`;
  - the receive and update state enums;
  - `SETTLE_W`=8.
- Sub-module `dac_frame_rx` holds the receive FSM, bit counter, payload shift register and parity check. It outputs `frm_valid`, `frm_addr`, `frm_payload` and `frm_perr`, each valid for one cycle.
- The top level holds the register file, the update FSM, the settle counter and the pending flag.

## Test plan
- Reset, then a DATA frame with payload 0xA5, then `ldac` pulse: `data_out`=0xA5 on the `ldac` edge, `busy` high 16 cycles, `done` pulses once.
- Settle register written to 0, then `ldac`: `busy` high 1 cycle, `done` on the next cycle.
- VREF frame with 0x3C and bad parity: `err`=1, VREF shadow unchanged. The next good VREF frame with 0x09 gives `err`=0, and after `ldac`, `vref_out`=9.
- `auto`=1, then a DATA frame with 0x7E: the update starts one cycle after acceptance with no `ldac`. A second `ldac` during settle is served right after `done`. A third `ldac` in the same window is dropped.
- `rst_n` asserted mid-payload and mid-settle: all outputs return to 0, `busy`=0, no `done`. A fresh full frame is then accepted normally.

Source files
------------

// File: rtl/dac_ctrl_pkg.sv
// dac_ctrl_pkg: shared constants and state types for the DAC update sequencer
package dac_ctrl_pkg;
    localparam int SETTLE_W = 8;
    localparam logic [1:0] ADDR_VREF   = 2'b00;
    localparam logic [1:0] ADDR_DATA   = 2'b01;
    localparam logic [1:0] ADDR_SETTLE = 2'b10;
    localparam logic [1:0] ADDR_CTRL   = 2'b11;
    typedef enum logic [1:0] {RX_IDLE, RX_ADDR, RX_PAY, RX_PAR} rx_state_t;
    typedef enum logic {U_IDLE, U_SETTLE} u_state_t;
    function automatic logic [SETTLE_W-1:0] settle_load(input logic [SETTLE_W-1:0] v);
        return (v == '0) ? SETTLE_W'(1) : v;
    endfunction
endpackage

// File: rtl/dac_update_sequencer_if.sv
// dac_update_sequencer_if: serial frame pins, load request and DAC-facing outputs
interface dac_update_sequencer_if #(parameter int DATA_W = 8, parameter int VREF_W = 4);
    logic              sin;
    logic              sval;
    logic              ldac;
    logic [VREF_W-1:0] vref_out;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;
    logic              err;
    modport master (output sin, sval, ldac, input vref_out, data_out, busy, done, err);
    modport slave  (input sin, sval, ldac, output vref_out, data_out, busy, done, err);
endinterface

// File: rtl/dac_frame_rx.sv
// dac_frame_rx: strobed serial receiver for start/addr/payload/even-parity frames
module dac_frame_rx import dac_ctrl_pkg::*; #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sval,
    output logic              frm_valid,
    output logic [1:0]        frm_addr,
    output logic [DATA_W-1:0] frm_payload,
    output logic              frm_perr
);
    localparam int CW = $clog2(DATA_W);
    rx_state_t         rx_state, rx_nxt;
    logic [CW-1:0]     cnt;
    logic [DATA_W+1:0] sr;
    logic              par;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_nxt;
    always_comb begin
        rx_nxt = rx_state;
        if (sval)
            case (rx_state)
                RX_IDLE: rx_nxt = sin ? RX_ADDR : RX_IDLE;
                RX_ADDR: rx_nxt = (cnt == CW'(1)) ? RX_PAY : RX_ADDR;
                RX_PAY:  rx_nxt = (cnt == CW'(DATA_W - 1)) ? RX_PAR : RX_PAY;
                default: rx_nxt = RX_IDLE;
            endcase
    end
    // cnt restarts on every state change so each field counts from zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            sr  <= '0;
            par <= 1'b0;
        end else if (sval) begin
            cnt <= (rx_nxt != rx_state) ? '0 : cnt + 1'b1;
            if (rx_state == RX_ADDR || rx_state == RX_PAY) begin
                sr  <= {sr[DATA_W:0], sin};
                par <= par ^ sin;
            end else if (rx_state == RX_IDLE) begin
                par <= 1'b0;
            end
        end
    always_comb begin
        frm_valid   = sval && (rx_state == RX_PAR);
        frm_perr    = frm_valid && (par ^ sin);
        frm_addr    = sr[DATA_W+1:DATA_W];
        frm_payload = sr[DATA_W-1:0];
    end
endmodule

// File: rtl/dac_update_sequencer.sv
// dac_update_sequencer: shadow registers from serial frames, load-triggered DAC update with settle timing
module dac_update_sequencer import dac_ctrl_pkg::*; #(
    parameter int DATA_W     = 8,
    parameter int VREF_W     = 4,
    parameter int SETTLE_RST = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    dac_update_sequencer_if.slave bus
);
    logic                frm_valid, frm_perr, acc;
    logic [1:0]          frm_addr;
    logic [DATA_W-1:0]   frm_payload;
    logic [VREF_W-1:0]   vref_sh, vref_q;
    logic [DATA_W-1:0]   data_sh, data_q;
    logic [SETTLE_W-1:0] settle_r, scnt;
    logic                auto_r, auto_go, err_q, done_q, pending;
    logic                start, settle_end, busy;
    u_state_t            u_state, u_nxt;

    dac_frame_rx #(.DATA_W(DATA_W)) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (bus.sin),
        .sval        (bus.sval),
        .frm_valid   (frm_valid),
        .frm_addr    (frm_addr),
        .frm_payload (frm_payload),
        .frm_perr    (frm_perr)
    );

    assign acc = frm_valid && !frm_perr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vref_sh  <= '0;
            data_sh  <= '0;
            settle_r <= SETTLE_W'(SETTLE_RST);
            auto_r   <= 1'b0;
            auto_go  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (frm_valid) err_q <= frm_perr;
            if (acc && frm_addr == ADDR_VREF)   vref_sh  <= frm_payload[VREF_W-1:0];
            if (acc && frm_addr == ADDR_DATA)   data_sh  <= frm_payload;
            if (acc && frm_addr == ADDR_SETTLE) settle_r <= SETTLE_W'(frm_payload);
            if (acc && frm_addr == ADDR_CTRL)   auto_r   <= frm_payload[0];
            auto_go <= acc && (frm_addr == ADDR_DATA) && auto_r;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) u_state <= U_IDLE;
        else        u_state <= u_nxt;

    always_comb
        u_nxt = start ? U_SETTLE : settle_end ? U_IDLE : u_state;

    always_comb begin
        busy       = (u_state == U_SETTLE);
        start      = (u_state == U_IDLE) && (bus.ldac || auto_go || pending);
        settle_end = busy && (scnt == SETTLE_W'(1));
    end

    // outputs load from the pre-edge shadows, so a same-edge frame write waits for the next update
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vref_q  <= '0;
            data_q  <= '0;
            scnt    <= '0;
            done_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            done_q <= settle_end;
            if (start) begin
                vref_q  <= vref_sh;
                data_q  <= data_sh;
                scnt    <= settle_load(settle_r);
                pending <= 1'b0;
            end else if (busy) begin
                scnt <= scnt - 1'b1;
                if (bus.ldac) pending <= 1'b1;
            end
        end

    assign bus.vref_out = vref_q;
    assign bus.data_out = data_q;
    assign bus.busy     = busy;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule
